// File: rtl/adv_i2c_config.sv
// ADV7511 power-up register sequencer driving an I2C byte-write master.
// Optional `ADV_CFG_HPD_RERUN_EN: rerun the table on a hot-plug rising edge.
module adv_i2c_config #(
  parameter logic [6:0]  DEV_ADDR       = 7'h39,
  parameter int unsigned STARTUP_CYCLES = 200000,
  parameter int unsigned RETRY_MAX      = 3,
  parameter int unsigned RETRY_GAP      = 1000,
  parameter int unsigned ACK_TIMEOUT    = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hpd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [6:0] cmd_addr,
  output logic [7:0] cmd_reg,
  output logic [7:0] cmd_data,
  input  logic       done_valid,
  input  logic       done_nack,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [3:0] err_index
);

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned ATT_W      = 8;
  localparam int unsigned RERUN_WAIT = 1024;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(11);

  typedef enum logic [2:0] {
    S_WAIT_START, S_ISSUE, S_WAIT_ACK, S_NEXT, S_RETRY_WAIT, S_DONE, S_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ATT_W-1:0]   att_q, att_d, att_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d, start_last;
  logic               cmd_valid_q, cfg_busy_q, cfg_done_q, cfg_error_q;
  logic [7:0]         cmd_reg_q, cmd_data_q;
  logic [3:0]         err_index_q;
  logic               rerun_q, rerun_d, hpd_rise;

  // Fixed register/value table, {reg, data}
  function automatic logic [15:0] table_entry(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h4110;
      4'd1:    table_entry = 16'h9803;
      4'd2:    table_entry = 16'h9AE0;
      4'd3:    table_entry = 16'h9C30;
      4'd4:    table_entry = 16'h9D61;
      4'd5:    table_entry = 16'hA2A4;
      4'd6:    table_entry = 16'hA3A4;
      4'd7:    table_entry = 16'hE0D0;
      4'd8:    table_entry = 16'hF900;
      4'd9:    table_entry = 16'h1600;
      4'd10:   table_entry = 16'hAF06;
      4'd11:   table_entry = 16'hD6C0;
      default: table_entry = 16'h0000;
    endcase
  endfunction

`ifdef ADV_CFG_HPD_RERUN_EN
  logic [1:0] hpd_sync_q;
  logic       hpd_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpd_sync_q <= 2'b00;
      hpd_prev_q <= 1'b0;
    end else begin
      hpd_sync_q <= {hpd_sync_q[0], hpd};
      hpd_prev_q <= hpd_sync_q[1];
    end
  end

  assign hpd_rise   = hpd_sync_q[1] & ~hpd_prev_q;
  assign start_last = rerun_q ? CNT_W'(RERUN_WAIT - 1) : CNT_W'(STARTUP_CYCLES - 1);
`else
  logic unused_hpd;
  assign unused_hpd = hpd;
  assign hpd_rise   = 1'b0;
  assign start_last = CNT_W'(STARTUP_CYCLES - 1);
`endif

  assign att_next = att_q + ATT_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    att_d   = att_q;
    cnt_d   = cnt_q;
    rerun_d = rerun_q;
    case (state_q)
      S_WAIT_START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q >= start_last) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done_valid && !done_nack) begin
          state_d = S_NEXT;
        end else if (done_valid || (cnt_q == CNT_W'(ACK_TIMEOUT - 1))) begin
          cnt_d   = '0;
          att_d   = att_next;
          state_d = (CNT_W'(att_next) < CNT_W'(RETRY_MAX)) ? S_RETRY_WAIT : S_ERROR;
        end
      end
      S_NEXT: begin
        att_d = '0;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_RETRY_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q >= CNT_W'(RETRY_GAP - 1)) begin
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_DONE, S_ERROR: begin
        // Hot-plug wipes the transmitter's registers, so start over quickly
        if (hpd_rise) begin
          idx_d   = '0;
          att_d   = '0;
          cnt_d   = '0;
          rerun_d = 1'b1;
          state_d = S_WAIT_START;
        end
      end
      default: state_d = S_WAIT_START;
    endcase
  end

  // Outputs are registered from next-state so they line up with state_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT_START;
      idx_q       <= '0;
      att_q       <= '0;
      cnt_q       <= '0;
      rerun_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_reg_q   <= 8'h00;
      cmd_data_q  <= 8'h00;
      cfg_busy_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_error_q <= 1'b0;
      err_index_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      att_q       <= att_d;
      cnt_q       <= cnt_d;
      rerun_q     <= rerun_d;
      cmd_valid_q <= (state_d == S_ISSUE);
      if (state_d == S_ISSUE) begin
        {cmd_reg_q, cmd_data_q} <= table_entry(idx_d);
      end
      cfg_busy_q  <= (state_d != S_DONE) && (state_d != S_ERROR);
      cfg_done_q  <= (state_d == S_DONE);
      cfg_error_q <= (state_d == S_ERROR);
      err_index_q <= (state_d == S_ERROR) ? idx_d : 4'h0;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = DEV_ADDR;
  assign cmd_reg   = cmd_reg_q;
  assign cmd_data  = cmd_data_q;
  assign cfg_busy  = cfg_busy_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_error = cfg_error_q;
  assign err_index = err_index_q;

endmodule
